// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder step per PH cycle, LSB first, with a registered carry loop.
// Optional subtract mode (SUB port) is built when SERIAL_ADD_SUB_EN is defined.
module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             PH,
   input  logic             RST_N,
   input  logic             START,
   output logic             READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             SUB,
`endif
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             DONE,
   input  logic             ACK
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic [1:0]       fa;

   // Returns {carry, sum} of a single-bit full adder.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      fa      = full_add(a_sr_q[0], b_sr_q[0], carry_q);

      case (state_q)
         IDLE: begin
            if (START) begin
               a_sr_d  = A;
               b_sr_d  = B;
               carry_d = CIN;
`ifdef SERIAL_ADD_SUB_EN
               // Two's-complement subtract: A + ~B + 1; final carry means no borrow.
               if (SUB) begin
                  b_sr_d  = ~B;
                  carry_d = 1'b1;
               end
`endif
               s_sr_d  = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            carry_d           = fa[1];
            s_sr_d            = s_sr_q >> 1;
            s_sr_d[WIDTH-1]   = fa[0];
            a_sr_d            = a_sr_q >> 1;
            b_sr_d            = b_sr_q >> 1;
            if (cnt_q == CNT_LAST) begin
               // Result registers are loaded only here so S/COUT stay put between ops.
               cnt_d   = '0;
               s_d     = s_sr_d;
               cout_d  = fa[1];
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (ACK) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge PH or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

   assign READY = (state_q == IDLE);
   assign DONE  = (state_q == HOLD);
   assign S     = s_q;
   assign COUT  = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8); subtract vectors under SERIAL_ADD_SUB_EN.
module tb_bit_serial_adder;

   localparam int WIDTH = 8;

   logic             PH;
   logic             RST_N;
   logic             START;
   logic             READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
`ifdef SERIAL_ADD_SUB_EN
   logic             SUB;
`endif
   logic [WIDTH-1:0] S;
   logic             COUT;
   logic             DONE;
   logic             ACK;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   bit_serial_adder #(.WIDTH(WIDTH)) dut (
      .PH    (PH),
      .RST_N (RST_N),
      .START (START),
      .READY (READY),
      .A     (A),
      .B     (B),
      .CIN   (CIN),
`ifdef SERIAL_ADD_SUB_EN
      .SUB   (SUB),
`endif
      .S     (S),
      .COUT  (COUT),
      .DONE  (DONE),
      .ACK   (ACK)
   );

   initial begin
      PH = 1'b0;
      forever #5 PH = ~PH;
   end

   always @(posedge PH) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge PH);
      #1;
   endtask

   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           output int acc_cyc);
      START = 1'b1;
      A     = a;
      B     = b;
      CIN   = cin;
      chk("ready_before_accept", READY, 1);
      tick();
      acc_cyc = cyc;
      START = 1'b0;
      A     = ~a;
      B     = ~b;
      CIN   = ~cin;
      chk("ready_after_accept", READY, 0);
   endtask

   task automatic wait_done(input string tag, input logic [7:0] es, input logic ec);
      int n;
      n = 0;
      while (DONE !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, WIDTH);
      chk({tag, "_s"}, S, es);
      chk({tag, "_cout"}, COUT, ec);
   endtask

   task automatic do_ack;
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      chk("ack_done_low", DONE, 0);
      chk("ack_ready", READY, 1);
   endtask

   logic [7:0] tab_a [4] = '{8'h12, 8'h80, 8'hA5, 8'h7F};
   logic [7:0] tab_b [4] = '{8'h34, 8'h80, 8'h5A, 8'h01};
   logic       tab_c [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [7:0] tab_s [4] = '{8'h47, 8'h00, 8'h00, 8'h80};
   logic       tab_o [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      int t;
      int t_prev;
      RST_N = 1'b1;
      START = 1'b0;
      ACK   = 1'b0;
      A     = '0;
      B     = '0;
      CIN   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      SUB   = 1'b0;
`endif
      #2 RST_N = 1'b0;
      tick();
      tick();
      chk("rst_done", DONE, 0);
      chk("rst_s", S, 0);
      chk("rst_cout", COUT, 0);
      RST_N = 1'b1;
      tick();
      chk("rst_ready", READY, 1);

      start_op(8'h5A, 8'h3C, 1'b0, t);
      wait_done("add_5a_3c", 8'h96, 1'b0);
      do_ack();
      start_op(8'hFF, 8'h01, 1'b0, t);
      wait_done("add_ff_01", 8'h00, 1'b1);
      do_ack();
      start_op(8'hFF, 8'hFF, 1'b1, t);
      wait_done("add_ff_ff_c", 8'hFF, 1'b1);
      do_ack();

      // Result held while ACK low; START ignored in HOLD.
      start_op(8'h33, 8'h44, 1'b1, t);
      wait_done("hold_op", 8'h78, 1'b0);
      for (int i = 0; i < 5; i++) begin
         START = 1'b1;
         A     = 8'h01;
         B     = 8'h01;
         tick();
         chk("hold_done", DONE, 1);
         chk("hold_s", S, 8'h78);
         chk("hold_cout", COUT, 0);
         chk("hold_ready", READY, 0);
      end
      A     = 8'h0A;
      B     = 8'h05;
      CIN   = 1'b0;
      ACK   = 1'b1;
      tick();
      ACK   = 1'b0;
      chk("ack_start_done", DONE, 0);
      chk("ack_start_ready", READY, 1);
      tick();
      START = 1'b0;
      chk("post_hold_accept", READY, 0);
      wait_done("post_hold_op", 8'h0F, 1'b0);
      do_ack();

      // Reset in the middle of an operation.
      start_op(8'h11, 8'h22, 1'b0, t);
      tick();
      tick();
      tick();
      RST_N = 1'b0;
      #1;
      chk("midrst_done", DONE, 0);
      chk("midrst_s", S, 0);
      chk("midrst_cout", COUT, 0);
      tick();
      tick();
      tick();
      RST_N = 1'b1;
      tick();
      chk("midrst_ready", READY, 1);
      start_op(8'h01, 8'h02, 1'b0, t);
      wait_done("after_rst", 8'h03, 1'b0);
      do_ack();

      // Back-to-back ops, ACK in the same cycle DONE is seen.
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         start_op(tab_a[i], tab_b[i], tab_c[i], t);
         if (i > 0) chk("b2b_spacing", t - t_prev, 10);
         t_prev = t;
         wait_done("b2b", tab_s[i], tab_o[i]);
         ACK = 1'b1;
         tick();
         ACK = 1'b0;
      end
      chk("b2b_final_ready", READY, 1);

`ifdef SERIAL_ADD_SUB_EN
      SUB = 1'b1;
      start_op(8'h10, 8'h01, 1'b0, t);
      wait_done("sub_10_01", 8'h0F, 1'b1);
      do_ack();
      start_op(8'h00, 8'h01, 1'b1, t);
      wait_done("sub_00_01", 8'hFF, 1'b0);
      do_ack();
      SUB = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
